// File: rtl/slc3_isdu.sv
`default_nettype none
// ============================================================================
// Module   : slc3_isdu
// Purpose  : SLC-3 instruction sequence/decode FSM. Optional PAUSE instruction
//            (opcode 1101) is built when SLC3_PAUSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module slc3_isdu #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       MARMUX,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
    S04, S21, S20, S06, S25, S27, S07, S23, S16
`ifdef SLC3_PAUSE_EN
    , PAUSE1, PAUSE2
`endif
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       sr2mux;
    logic       addr1mux;
    logic       drmux;
    logic       sr1mux;
    logic       mio_en;
    logic       mem_oe;
    logic       mem_we;
  } ctrl_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  ctrl_t      r_ctl;

  function automatic ctrl_t decode(input state_t s, input logic ir5);
    ctrl_t c;
    c        = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    case (s)
      S18: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
      end
      S33, S25: begin
        c.mem_oe = 1'b0;
        c.mio_en = 1'b1;
        c.ld_mdr = 1'b1;
      end
      S35: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      S32: c.ld_ben = 1'b1;
      S01, S05: begin
        c.sr1mux   = 1'b1;
        c.sr2mux   = ir5;
        c.aluk     = (s == S05) ? 2'b01 : 2'b00;
        c.gate_alu = 1'b1;
        c.drmux    = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S09: begin
        c.sr1mux   = 1'b1;
        c.aluk     = 2'b10;
        c.gate_alu = 1'b1;
        c.drmux    = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S22: begin
        c.addr2mux = 2'b10;
        c.pcmux    = 2'b01;
        c.ld_pc    = 1'b1;
      end
      S12: begin
        c.sr1mux   = 1'b1;
        c.aluk     = 2'b11;
        c.gate_alu = 1'b1;
        c.pcmux    = 2'b10;
        c.ld_pc    = 1'b1;
      end
      // R7 <- PC: DRMUX stays 0 to select R7
      S04: begin
        c.gate_pc = 1'b1;
        c.ld_reg  = 1'b1;
      end
      S21: begin
        c.addr2mux = 2'b11;
        c.pcmux    = 2'b01;
        c.ld_pc    = 1'b1;
      end
      S20: begin
        c.sr1mux   = 1'b1;
        c.addr1mux = 1'b1;
        c.pcmux    = 2'b01;
        c.ld_pc    = 1'b1;
      end
      S06, S07: begin
        c.sr1mux      = 1'b1;
        c.addr1mux    = 1'b1;
        c.addr2mux    = 2'b01;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
      end
      S27: begin
        c.gate_mdr = 1'b1;
        c.drmux    = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S23: begin
        c.aluk     = 2'b11;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
      end
      S16: c.mem_we = 1'b0;
`ifdef SLC3_PAUSE_EN
      PAUSE1: c.ld_led = 1'b1;
`endif
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      HALTED: if (Run) w_next = S18;
      S18:    w_next = S33;
      S33:    if (r_cnt == WAIT_LAST) w_next = S35;
      S35:    w_next = S32;
      S32: begin
        case (Opcode)
          4'b0001: w_next = S01;
          4'b0101: w_next = S05;
          4'b1001: w_next = S09;
          4'b0000: w_next = S00;
          4'b1100: w_next = S12;
          4'b0100: w_next = S04;
          4'b0110: w_next = S06;
          4'b0111: w_next = S07;
`ifdef SLC3_PAUSE_EN
          4'b1101: w_next = PAUSE1;
`endif
          default: w_next = S18;
        endcase
      end
      S00:    w_next = BEN ? S22 : S18;
      S04:    w_next = IR_11 ? S21 : S20;
      S06:    w_next = S25;
      S25:    if (r_cnt == WAIT_LAST) w_next = S27;
      S07:    w_next = S23;
      S23:    w_next = S16;
      S16:    if (r_cnt == WAIT_LAST) w_next = S18;
      S01, S05, S09, S12, S22, S21, S20, S27: w_next = S18;
`ifdef SLC3_PAUSE_EN
      PAUSE1: if (Continue) w_next = PAUSE2;
      PAUSE2: if (!Continue) w_next = S18;
`endif
      default: w_next = HALTED;
    endcase
  end

  // Counter runs only while a memory state holds itself; any entry clears it
  always_comb begin
    w_cnt_next = 4'd0;
    if ((w_next == r_state) && (r_state inside {S33, S25, S16}))
      w_cnt_next = r_cnt + 4'd1;
  end

`ifndef SLC3_PAUSE_EN
  logic w_unused_continue;
  assign w_unused_continue = Continue;
`endif

  // Outputs are decoded from the next state so the registered copy tracks r_state
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= HALTED;
      r_cnt   <= 4'd0;
      r_ctl   <= decode(HALTED, 1'b0);
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_ctl   <= decode(w_next, IR_5);
    end
  end

  assign LD_MAR     = r_ctl.ld_mar;
  assign LD_MDR     = r_ctl.ld_mdr;
  assign LD_IR      = r_ctl.ld_ir;
  assign LD_BEN     = r_ctl.ld_ben;
  assign LD_CC      = r_ctl.ld_cc;
  assign LD_REG     = r_ctl.ld_reg;
  assign LD_PC      = r_ctl.ld_pc;
  assign LD_LED     = r_ctl.ld_led;
  assign GatePC     = r_ctl.gate_pc;
  assign GateMDR    = r_ctl.gate_mdr;
  assign GateALU    = r_ctl.gate_alu;
  assign GateMARMUX = r_ctl.gate_marmux;
  assign PCMUX      = r_ctl.pcmux;
  assign ADDR2MUX   = r_ctl.addr2mux;
  assign ALUK       = r_ctl.aluk;
  assign SR2MUX     = r_ctl.sr2mux;
  assign ADDR1MUX   = r_ctl.addr1mux;
  assign DRMUX      = r_ctl.drmux;
  assign SR1MUX     = r_ctl.sr1mux;
  assign MARMUX     = 1'b0;
  assign MIO_EN     = r_ctl.mio_en;
  assign Mem_OE     = r_ctl.mem_oe;
  assign Mem_WE     = r_ctl.mem_we;

endmodule
`default_nettype wire

// File: tb/tb_slc3_isdu.sv
`default_nettype none
// Testbench for slc3_isdu: two instances (MEM_WAIT 2 and 3) checked cycle by
// cycle against per-instruction expected control traces.
module tb_slc3_isdu;

  localparam logic [25:0] LD_MAR_B  = 26'h0000001;
  localparam logic [25:0] LD_MDR_B  = 26'h0000002;
  localparam logic [25:0] LD_IR_B   = 26'h0000004;
  localparam logic [25:0] LD_BEN_B  = 26'h0000008;
  localparam logic [25:0] LD_CC_B   = 26'h0000010;
  localparam logic [25:0] LD_REG_B  = 26'h0000020;
  localparam logic [25:0] LD_PC_B   = 26'h0000040;
  localparam logic [25:0] LD_LED_B  = 26'h0000080;
  localparam logic [25:0] G_PC      = 26'h0000100;
  localparam logic [25:0] G_MDR     = 26'h0000200;
  localparam logic [25:0] G_ALU     = 26'h0000400;
  localparam logic [25:0] G_MARMUX  = 26'h0000800;
  localparam logic [25:0] PC_ADDER  = 26'h0001000;
  localparam logic [25:0] PC_BUS    = 26'h0002000;
  localparam logic [25:0] A2_OFF6   = 26'h0004000;
  localparam logic [25:0] A2_OFF9   = 26'h0008000;
  localparam logic [25:0] A2_OFF11  = 26'h000C000;
  localparam logic [25:0] ALU_AND   = 26'h0010000;
  localparam logic [25:0] ALU_NOT   = 26'h0020000;
  localparam logic [25:0] ALU_PASS  = 26'h0030000;
  localparam logic [25:0] SR2_IMM   = 26'h0040000;
  localparam logic [25:0] A1_SR1    = 26'h0080000;
  localparam logic [25:0] DR_IR     = 26'h0100000;
  localparam logic [25:0] SR1_86    = 26'h0200000;
  localparam logic [25:0] MIO       = 26'h0800000;
  localparam logic [25:0] OE_N      = 26'h1000000;
  localparam logic [25:0] WE_N      = 26'h2000000;
  localparam logic [25:0] IDLE      = OE_N | WE_N;
  localparam logic [25:0] RD        = WE_N | MIO | LD_MDR_B;
  localparam logic [25:0] WR        = OE_N;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset2, Reset3, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;

  logic ld_mar2, ld_mdr2, ld_ir2, ld_ben2, ld_cc2, ld_reg2, ld_pc2, ld_led2;
  logic gpc2, gmdr2, galu2, gmm2, sr2m2, a1m2, drm2, sr1m2, marm2, mio2, oe2, we2;
  logic [1:0] pcm2, a2m2, aluk2;
  logic ld_mar3, ld_mdr3, ld_ir3, ld_ben3, ld_cc3, ld_reg3, ld_pc3, ld_led3;
  logic gpc3, gmdr3, galu3, gmm3, sr2m3, a1m3, drm3, sr1m3, marm3, mio3, oe3, we3;
  logic [1:0] pcm3, a2m3, aluk3;

  slc3_isdu #(.MEM_WAIT(2)) u_dut2 (
    .Clk(Clk), .Reset(Reset2), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(ld_mar2), .LD_MDR(ld_mdr2), .LD_IR(ld_ir2), .LD_BEN(ld_ben2),
    .LD_CC(ld_cc2), .LD_REG(ld_reg2), .LD_PC(ld_pc2), .LD_LED(ld_led2),
    .GatePC(gpc2), .GateMDR(gmdr2), .GateALU(galu2), .GateMARMUX(gmm2),
    .PCMUX(pcm2), .ADDR2MUX(a2m2), .ALUK(aluk2), .SR2MUX(sr2m2),
    .ADDR1MUX(a1m2), .DRMUX(drm2), .SR1MUX(sr1m2), .MARMUX(marm2),
    .MIO_EN(mio2), .Mem_OE(oe2), .Mem_WE(we2)
  );

  slc3_isdu #(.MEM_WAIT(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset3), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(ld_mar3), .LD_MDR(ld_mdr3), .LD_IR(ld_ir3), .LD_BEN(ld_ben3),
    .LD_CC(ld_cc3), .LD_REG(ld_reg3), .LD_PC(ld_pc3), .LD_LED(ld_led3),
    .GatePC(gpc3), .GateMDR(gmdr3), .GateALU(galu3), .GateMARMUX(gmm3),
    .PCMUX(pcm3), .ADDR2MUX(a2m3), .ALUK(aluk3), .SR2MUX(sr2m3),
    .ADDR1MUX(a1m3), .DRMUX(drm3), .SR1MUX(sr1m3), .MARMUX(marm3),
    .MIO_EN(mio3), .Mem_OE(oe3), .Mem_WE(we3)
  );

  logic [25:0] w_obs2, w_obs3;
  assign w_obs2 = {we2, oe2, mio2, marm2, sr1m2, drm2, a1m2, sr2m2, aluk2, a2m2, pcm2,
                   gmm2, galu2, gmdr2, gpc2, ld_led2, ld_pc2, ld_reg2, ld_cc2,
                   ld_ben2, ld_ir2, ld_mdr2, ld_mar2};
  assign w_obs3 = {we3, oe3, mio3, marm3, sr1m3, drm3, a1m3, sr2m3, aluk3, a2m3, pcm3,
                   gmm3, galu3, gmdr3, gpc3, ld_led3, ld_pc3, ld_reg3, ld_cc3,
                   ld_ben3, ld_ir3, ld_mdr3, ld_mar3};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur      = 0;
  logic [25:0] exp_q[$];
  bit          cont_q[$];

  task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] observed();
    return (cur == 0) ? w_obs2 : w_obs3;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_rst(input logic v);
    if (cur == 0) Reset2 = v;
    else          Reset3 = v;
  endtask

  task automatic push(input logic [25:0] v, input bit c);
    exp_q.push_back(v);
    cont_q.push_back(c);
  endtask

  // Expected control trace of one instruction, starting at its fetch cycle
  task automatic build(input int w, input logic [3:0] op, input bit ir5, input bit ir11,
                       input bit ben, input int k, input int m);
    exp_q.delete();
    cont_q.delete();
    push(IDLE | G_PC | LD_MAR_B | LD_PC_B, 1'b0);
    repeat (w) push(RD, 1'b0);
    push(IDLE | G_MDR | LD_IR_B, 1'b0);
    push(IDLE | LD_BEN_B, 1'b0);
    case (op)
      4'b0001: push(IDLE | SR1_86 | (ir5 ? SR2_IMM : 26'h0) | G_ALU | DR_IR | LD_REG_B | LD_CC_B, 1'b0);
      4'b0101: push(IDLE | SR1_86 | (ir5 ? SR2_IMM : 26'h0) | ALU_AND | G_ALU | DR_IR | LD_REG_B | LD_CC_B, 1'b0);
      4'b1001: push(IDLE | SR1_86 | ALU_NOT | G_ALU | DR_IR | LD_REG_B | LD_CC_B, 1'b0);
      4'b0000: begin
        push(IDLE, 1'b0);
        if (ben) push(IDLE | A2_OFF9 | PC_ADDER | LD_PC_B, 1'b0);
      end
      4'b1100: push(IDLE | SR1_86 | ALU_PASS | G_ALU | PC_BUS | LD_PC_B, 1'b0);
      4'b0100: begin
        push(IDLE | G_PC | LD_REG_B, 1'b0);
        if (ir11) push(IDLE | A2_OFF11 | PC_ADDER | LD_PC_B, 1'b0);
        else      push(IDLE | SR1_86 | A1_SR1 | PC_ADDER | LD_PC_B, 1'b0);
      end
      4'b0110: begin
        push(IDLE | SR1_86 | A1_SR1 | A2_OFF6 | G_MARMUX | LD_MAR_B, 1'b0);
        repeat (w) push(RD, 1'b0);
        push(IDLE | G_MDR | DR_IR | LD_REG_B | LD_CC_B, 1'b0);
      end
      4'b0111: begin
        push(IDLE | SR1_86 | A1_SR1 | A2_OFF6 | G_MARMUX | LD_MAR_B, 1'b0);
        push(IDLE | ALU_PASS | G_ALU | LD_MDR_B, 1'b0);
        repeat (w) push(WR, 1'b0);
      end
`ifdef SLC3_PAUSE_EN
      4'b1101: begin
        repeat (k) push(IDLE | LD_LED_B, 1'b0);
        push(IDLE | LD_LED_B, 1'b1);
        repeat (m - 1) push(IDLE, 1'b1);
        push(IDLE, 1'b0);
      end
`endif
      default: ;
    endcase
  endtask

  // Entered with the DUT in its fetch cycle; leaves it in the next fetch cycle
  task automatic run_instr(input int w, input logic [3:0] op, input bit ir5, input bit ir11,
                           input bit ben, input bit abort);
    Opcode = op;
    IR_5   = ir5;
    IR_11  = ir11;
    BEN    = ben;
    build(w, op, ir5, ir11, ben, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    foreach (exp_q[i]) begin
      check_eq($sformatf("w%0d_op%b_c%0d", w, op, i), observed(), exp_q[i]);
      Continue = cont_q[i];
      Run      = 1'($urandom);
      if (abort && i == w + 5) begin
        set_rst(1'b0);
        Run = 1'b0;
        step();
        check_eq("mid_reset_halt", observed(), IDLE);
        set_rst(1'b1);
        step();
        check_eq("post_reset_idle0", observed(), IDLE);
        step();
        check_eq("post_reset_idle1", observed(), IDLE);
        Run = 1'b1;
        step();
        return;
      end
      step();
    end
  endtask

  initial begin
    int w;
    Reset2   = 1'b0;
    Reset3   = 1'b0;
    Run      = 1'b0;
    Continue = 1'b0;
    Opcode   = 4'h0;
    IR_5     = 1'b0;
    IR_11    = 1'b0;
    BEN      = 1'b0;
    step();
    step();
    check_eq("reset_dut2", w_obs2, IDLE);
    check_eq("reset_dut3", w_obs3, IDLE);
    for (int p = 0; p < 2; p++) begin
      cur = p;
      w   = (p == 0) ? 2 : 3;
      Reset2 = (p == 0);
      Reset3 = (p == 1);
      Run    = 1'b0;
      step();
      for (int h = 0; h < 3; h++) begin
        step();
        check_eq($sformatf("halted_w%0d_%0d", w, h), observed(), IDLE);
      end
      Run = 1'b1;
      step();
      run_instr(w, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
      run_instr(w, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      run_instr(w, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(w, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(w, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(w, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(w, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(w, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(w, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
      run_instr(w, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(w, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(w, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int r = 0; r < 40; r++)
        run_instr(w, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
